// File: rtl/rob_commit_queue_pkg.sv
// Shared types and sizes for the 2-wide reorder buffer.
// The packed entry layout keeps the valid, done, arf, rrf and pc fields
// in one place for the storage array and the top.
package rob_commit_queue_pkg;

  localparam int ROB_IDX_W = 4;
  localparam int ARF_IDX_W = 3;
  localparam int RRF_IDX_W = 7;
  localparam int PC_W      = 16;
  localparam int ROB_DEPTH = 1 << ROB_IDX_W;

  typedef logic [ROB_IDX_W-1:0] rob_idx_t;
  typedef logic [ROB_IDX_W:0]   rob_ptr_t;

  typedef struct packed {
    logic                 valid;
    logic                 done;
    logic [ARF_IDX_W-1:0] arf;
    logic [RRF_IDX_W-1:0] rrf;
    logic [PC_W-1:0]      pc;
  } rob_entry_t;

  localparam int ENTRY_W = $bits(rob_entry_t);

  // Number of set bits in a 2-bit strobe, widened to a full pointer.
  function automatic rob_ptr_t popCount2(input logic [1:0] v);
    return rob_ptr_t'({1'b0, v[0]}) + rob_ptr_t'({1'b0, v[1]});
  endfunction

endpackage

// File: rtl/rob_entry_array.sv
// Entry storage for the ROB: two allocate write ports, two done-set ports,
// two retire-clear ports and two read ports for the head and head+1 slots.
module rob_entry_array
  import rob_commit_queue_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_clear,
  input  logic                 i_allocEn0,
  input  rob_idx_t             i_allocIdx0,
  input  logic [ARF_IDX_W-1:0] i_allocArf0,
  input  logic [RRF_IDX_W-1:0] i_allocRrf0,
  input  logic [PC_W-1:0]      i_allocPc0,
  input  logic                 i_allocEn1,
  input  rob_idx_t             i_allocIdx1,
  input  logic [ARF_IDX_W-1:0] i_allocArf1,
  input  logic [RRF_IDX_W-1:0] i_allocRrf1,
  input  logic [PC_W-1:0]      i_allocPc1,
  input  logic                 i_wbEn0,
  input  rob_idx_t             i_wbTag0,
  input  logic                 i_wbEn1,
  input  rob_idx_t             i_wbTag1,
  input  logic                 i_retireEn0,
  input  logic                 i_retireEn1,
  input  rob_idx_t             i_rdIdx0,
  input  rob_idx_t             i_rdIdx1,
  output logic [ENTRY_W-1:0]   o_rdEntry0,
  output logic [ENTRY_W-1:0]   o_rdEntry1
);

  logic [ROB_DEPTH-1:0] r_valid;
  logic [ROB_DEPTH-1:0] r_done;
  logic [ARF_IDX_W-1:0] r_arf [ROB_DEPTH];
  logic [RRF_IDX_W-1:0] r_rrf [ROB_DEPTH];
  logic [PC_W-1:0]      r_pc  [ROB_DEPTH];

  // Status bits: writeback marks live entries done, retire clears them
  // (after writeback so a late duplicate cannot revive a retired slot),
  // allocation opens fresh entries in free slots.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_valid <= '0;
      r_done  <= '0;
    end else begin
      if (i_wbEn0 && r_valid[i_wbTag0]) r_done[i_wbTag0] <= 1'b1;
      if (i_wbEn1 && r_valid[i_wbTag1]) r_done[i_wbTag1] <= 1'b1;
      if (i_retireEn0) begin
        r_valid[i_rdIdx0] <= 1'b0;
        r_done[i_rdIdx0]  <= 1'b0;
      end
      if (i_retireEn1) begin
        r_valid[i_rdIdx1] <= 1'b0;
        r_done[i_rdIdx1]  <= 1'b0;
      end
      if (i_allocEn0) begin
        r_valid[i_allocIdx0] <= 1'b1;
        r_done[i_allocIdx0]  <= 1'b0;
      end
      if (i_allocEn1) begin
        r_valid[i_allocIdx1] <= 1'b1;
        r_done[i_allocIdx1]  <= 1'b0;
      end
    end
  end

  // Payload is only meaningful while valid is set, so it needs no reset.
  always_ff @(posedge clk) begin
    if (i_allocEn0) begin
      r_arf[i_allocIdx0] <= i_allocArf0;
      r_rrf[i_allocIdx0] <= i_allocRrf0;
      r_pc[i_allocIdx0]  <= i_allocPc0;
    end
    if (i_allocEn1) begin
      r_arf[i_allocIdx1] <= i_allocArf1;
      r_rrf[i_allocIdx1] <= i_allocRrf1;
      r_pc[i_allocIdx1]  <= i_allocPc1;
    end
  end

  assign o_rdEntry0 = {r_valid[i_rdIdx0], r_done[i_rdIdx0], r_arf[i_rdIdx0], r_rrf[i_rdIdx0], r_pc[i_rdIdx0]};
  assign o_rdEntry1 = {r_valid[i_rdIdx1], r_done[i_rdIdx1], r_arf[i_rdIdx1], r_rrf[i_rdIdx1], r_pc[i_rdIdx1]};

endmodule

// File: rtl/rob_commit_queue.sv
// 2-wide in-order reorder buffer. Owns the head/tail pointers, decides
// allocation and retirement each cycle and registers the commit outputs.
// Occupancy is tail-head on the extended pointers, so 16 entries is
// distinguishable from empty.
module rob_commit_queue
  import rob_commit_queue_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 flush,
  input  logic [1:0]           disp_valid,
  input  logic [ARF_IDX_W-1:0] disp_arf0,
  input  logic [ARF_IDX_W-1:0] disp_arf1,
  input  logic [RRF_IDX_W-1:0] disp_rrf0,
  input  logic [RRF_IDX_W-1:0] disp_rrf1,
  input  logic [PC_W-1:0]      disp_pc0,
  input  logic [PC_W-1:0]      disp_pc1,
  output logic                 alloc_ready,
  output logic [ROB_IDX_W-1:0] alloc_tag0,
  output logic [ROB_IDX_W-1:0] alloc_tag1,
  input  logic [1:0]           wb_valid,
  input  logic [ROB_IDX_W-1:0] wb_tag0,
  input  logic [ROB_IDX_W-1:0] wb_tag1,
  output logic [1:0]           commit_valid,
  output logic [ARF_IDX_W-1:0] commit_arf0,
  output logic [ARF_IDX_W-1:0] commit_arf1,
  output logic [RRF_IDX_W-1:0] commit_rrf0,
  output logic [RRF_IDX_W-1:0] commit_rrf1,
  output logic [PC_W-1:0]      commit_pc0,
  output logic [PC_W-1:0]      commit_pc1,
  output logic [ROB_IDX_W:0]   rob_count,
  output logic                 rob_empty
);

  rob_ptr_t   r_head;
  rob_ptr_t   r_tail;
  rob_idx_t   w_headIdx0;
  rob_idx_t   w_headIdx1;
  logic       w_doAlloc;
  logic       w_alloc0;
  logic       w_alloc1;
  logic       w_retire0;
  logic       w_retire1;
  rob_entry_t w_head0;
  rob_entry_t w_head1;

  assign rob_count   = r_tail - r_head;
  assign rob_empty   = (rob_count == '0);
  assign alloc_ready = (rob_count <= rob_ptr_t'(ROB_DEPTH - 2));

  assign alloc_tag0 = r_tail[ROB_IDX_W-1:0];
  assign alloc_tag1 = r_tail[ROB_IDX_W-1:0] + rob_idx_t'(disp_valid[0]);

  assign w_doAlloc = !stall && !flush && alloc_ready;
  assign w_alloc0  = w_doAlloc && disp_valid[0];
  assign w_alloc1  = w_doAlloc && disp_valid[1];

  assign w_headIdx0 = r_head[ROB_IDX_W-1:0];
  assign w_headIdx1 = r_head[ROB_IDX_W-1:0] + rob_idx_t'(1);

  assign w_retire0 = !stall && !flush && w_head0.valid && w_head0.done;
  assign w_retire1 = w_retire0 && w_head1.valid && w_head1.done;

  rob_entry_array u_entries (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (flush),
    .i_allocEn0  (w_alloc0),
    .i_allocIdx0 (alloc_tag0),
    .i_allocArf0 (disp_arf0),
    .i_allocRrf0 (disp_rrf0),
    .i_allocPc0  (disp_pc0),
    .i_allocEn1  (w_alloc1),
    .i_allocIdx1 (alloc_tag1),
    .i_allocArf1 (disp_arf1),
    .i_allocRrf1 (disp_rrf1),
    .i_allocPc1  (disp_pc1),
    .i_wbEn0     (wb_valid[0]),
    .i_wbTag0    (wb_tag0),
    .i_wbEn1     (wb_valid[1]),
    .i_wbTag1    (wb_tag1),
    .i_retireEn0 (w_retire0),
    .i_retireEn1 (w_retire1),
    .i_rdIdx0    (w_headIdx0),
    .i_rdIdx1    (w_headIdx1),
    .o_rdEntry0  (w_head0),
    .o_rdEntry1  (w_head1)
  );

  // Advance tail by the entries allocated and head by the entries retired.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      r_tail <= r_tail + popCount2({w_alloc1, w_alloc0});
      r_head <= r_head + popCount2({w_retire1, w_retire0});
    end
  end

  // Register the retiring entries; data holds its last value on idle cycles.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      commit_valid <= 2'b00;
      commit_arf0  <= '0;
      commit_arf1  <= '0;
      commit_rrf0  <= '0;
      commit_rrf1  <= '0;
      commit_pc0   <= '0;
      commit_pc1   <= '0;
    end else begin
      commit_valid <= {w_retire1, w_retire0};
      if (w_retire0) begin
        commit_arf0 <= w_head0.arf;
        commit_rrf0 <= w_head0.rrf;
        commit_pc0  <= w_head0.pc;
      end
      if (w_retire1) begin
        commit_arf1 <= w_head1.arf;
        commit_rrf1 <= w_head1.rrf;
        commit_pc1  <= w_head1.pc;
      end
    end
  end

endmodule

// File: tb/tb_rob_commit_queue.sv
// Directed bench for rob_commit_queue. Dispatched instructions that are
// expected to retire go into a scoreboard in program order; a negedge
// monitor pops and compares every retire strobe the ROB presents.
module tb_rob_commit_queue;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [1:0]  disp_valid;
  logic [2:0]  disp_arf0, disp_arf1;
  logic [6:0]  disp_rrf0, disp_rrf1;
  logic [15:0] disp_pc0, disp_pc1;
  logic        alloc_ready;
  logic [3:0]  alloc_tag0, alloc_tag1;
  logic [1:0]  wb_valid;
  logic [3:0]  wb_tag0, wb_tag1;
  logic [1:0]  commit_valid;
  logic [2:0]  commit_arf0, commit_arf1;
  logic [6:0]  commit_rrf0, commit_rrf1;
  logic [15:0] commit_pc0, commit_pc1;
  logic [4:0]  rob_count;
  logic        rob_empty;

  typedef struct {
    logic [2:0]  arf;
    logic [6:0]  rrf;
    logic [15:0] pc;
  } exp_t;

  exp_t       sbq[$];
  int         vectors;
  int         miscompares;
  int         seqNum;
  logic [3:0] nextTag;

  rob_commit_queue dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .flush        (flush),
    .disp_valid   (disp_valid),
    .disp_arf0    (disp_arf0),
    .disp_arf1    (disp_arf1),
    .disp_rrf0    (disp_rrf0),
    .disp_rrf1    (disp_rrf1),
    .disp_pc0     (disp_pc0),
    .disp_pc1     (disp_pc1),
    .alloc_ready  (alloc_ready),
    .alloc_tag0   (alloc_tag0),
    .alloc_tag1   (alloc_tag1),
    .wb_valid     (wb_valid),
    .wb_tag0      (wb_tag0),
    .wb_tag1      (wb_tag1),
    .commit_valid (commit_valid),
    .commit_arf0  (commit_arf0),
    .commit_arf1  (commit_arf1),
    .commit_rrf0  (commit_rrf0),
    .commit_rrf1  (commit_rrf1),
    .commit_pc0   (commit_pc0),
    .commit_pc1   (commit_pc1),
    .rob_count    (rob_count),
    .rob_empty    (rob_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction n carries arf n+1, rrf n+10, pc 0x100+4n (instr 0/1 -> arf 1,2 rrf 10,11).
  function automatic logic [2:0] arfOf(input int n);
    logic [31:0] v;
    v = n + 1;
    return v[2:0];
  endfunction

  function automatic logic [6:0] rrfOf(input int n);
    logic [31:0] v;
    v = n + 10;
    return v[6:0];
  endfunction

  function automatic logic [15:0] pcOf(input int n);
    logic [31:0] v;
    v = 32'h100 + 4 * n;
    return v[15:0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkCommit(input string name, input logic [2:0] arf, input logic [6:0] rrf, input logic [15:0] pc);
    exp_t e;
    if (sbq.size() == 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s: unexpected commit pc %0h, scoreboard empty", name, pc);
    end else begin
      e = sbq.pop_front();
      checkOutput({name, "_arf"}, 32'(arf), 32'(e.arf));
      checkOutput({name, "_rrf"}, 32'(rrf), 32'(e.rrf));
      checkOutput({name, "_pc"},  32'(pc),  32'(e.pc));
    end
  endtask

  // Monitor: every retire strobe must match the oldest outstanding instruction.
  always @(negedge clk) begin
    if (!reset && commit_valid != 2'b00) begin
      checkOutput("commit_order", 32'(commit_valid == 2'b10), 32'd0);
      if (commit_valid[0]) checkCommit("commit0", commit_arf0, commit_rrf0, commit_pc0);
      if (commit_valid[1]) checkCommit("commit1", commit_arf1, commit_rrf1, commit_pc1);
    end
  end

  // One cycle of stimulus. acc: the ROB should accept the dispatch (tags are
  // checked and the tag model advances); push: the entries should retire.
  task automatic applyStimulus(input logic [1:0] dv, input logic [1:0] wv,
                               input logic [3:0] t0, input logic [3:0] t1,
                               input logic st, input logic fl,
                               input bit acc, input bit push);
    int   s1;
    int   n;
    exp_t e;
    s1 = seqNum + (dv[0] ? 1 : 0);
    n  = (dv[0] ? 1 : 0) + (dv[1] ? 1 : 0);
    stall      = st;
    flush      = fl;
    wb_valid   = wv;
    wb_tag0    = t0;
    wb_tag1    = t1;
    disp_valid = dv;
    disp_arf0  = arfOf(seqNum);
    disp_rrf0  = rrfOf(seqNum);
    disp_pc0   = pcOf(seqNum);
    disp_arf1  = arfOf(s1);
    disp_rrf1  = rrfOf(s1);
    disp_pc1   = pcOf(s1);
    #1;
    if (acc) begin
      if (dv[0]) checkOutput("alloc_tag0", 32'(alloc_tag0), 32'(nextTag));
      if (dv[1]) checkOutput("alloc_tag1", 32'(alloc_tag1), 32'(nextTag + 4'(dv[0])));
      if (push && dv[0]) begin
        e.arf = arfOf(seqNum); e.rrf = rrfOf(seqNum); e.pc = pcOf(seqNum);
        sbq.push_back(e);
      end
      if (push && dv[1]) begin
        e.arf = arfOf(s1); e.rrf = rrfOf(s1); e.pc = pcOf(s1);
        sbq.push_back(e);
      end
      nextTag = nextTag + 4'(n);
      seqNum  = seqNum + n;
    end
    if (fl) nextTag = 4'd0;
    @(posedge clk);
    #1;
    stall      = 1'b0;
    flush      = 1'b0;
    wb_valid   = 2'b00;
    disp_valid = 2'b00;
  endtask

  task automatic idle();
    applyStimulus(2'b00, 2'b00, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [3:0] t;
    vectors     = 0;
    miscompares = 0;
    seqNum      = 0;
    nextTag     = 4'd0;
    reset       = 1'b1;
    stall       = 1'b0;
    flush       = 1'b0;
    disp_valid  = 2'b00;
    wb_valid    = 2'b00;
    wb_tag0     = 4'd0;
    wb_tag1     = 4'd0;
    disp_arf0 = '0; disp_arf1 = '0; disp_rrf0 = '0; disp_rrf1 = '0; disp_pc0 = '0; disp_pc1 = '0;

    // 1: reset for three cycles
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    checkOutput("rst_empty",  32'(rob_empty), 32'd1);
    checkOutput("rst_count",  32'(rob_count), 32'd0);
    checkOutput("rst_ready",  32'(alloc_ready), 32'd1);
    checkOutput("rst_commit", 32'(commit_valid), 32'd0);

    // 2: dual dispatch, both written back in one cycle, dual commit
    applyStimulus(2'b11, 2'b00, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("t2_count_alloc", 32'(rob_count), 32'd2);
    applyStimulus(2'b00, 2'b11, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t2_no_early_commit", 32'(commit_valid), 32'd0);
    idle();
    checkOutput("t2_commit_valid", 32'(commit_valid), 32'd3);
    checkOutput("t2_rrf0", 32'(commit_rrf0), 32'd10);
    checkOutput("t2_rrf1", 32'(commit_rrf1), 32'd11);
    checkOutput("t2_count_drained", 32'(rob_count), 32'd0);
    checkOutput("t2_empty", 32'(rob_empty), 32'd1);

    // 3: fill all 16 entries, overflow dispatch is dropped, then drain
    for (int i = 0; i < 8; i++) begin
      checkOutput("t3_fill_ready", 32'(alloc_ready), 32'd1);
      applyStimulus(2'b11, 2'b00, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    end
    checkOutput("t3_full_count", 32'(rob_count), 32'd16);
    checkOutput("t3_full_ready", 32'(alloc_ready), 32'd0);
    applyStimulus(2'b11, 2'b00, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t3_drop_count", 32'(rob_count), 32'd16);
    for (int k = 0; k < 8; k++) begin
      t = 4'(2 + 2 * k);
      applyStimulus(2'b00, 2'b11, t, t + 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    idle();
    checkOutput("t3_drain_count", 32'(rob_count), 32'd0);

    // 4: 20 entries through in pairs, tags wrap past 15
    for (int i = 0; i < 10; i++) begin
      t = nextTag;
      applyStimulus(2'b11, 2'b00, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      applyStimulus(2'b00, 2'b11, t, t + 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    idle();
    checkOutput("t4_count", 32'(rob_count), 32'd0);

    // 5a: younger done first holds both back until the older completes
    t = nextTag;
    applyStimulus(2'b11, 2'b00, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(2'b00, 2'b10, 4'd0, t + 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    checkOutput("t5_young_only", 32'(commit_valid), 32'd0);
    idle();
    checkOutput("t5_young_only_count", 32'(rob_count), 32'd2);
    applyStimulus(2'b00, 2'b01, t, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t5_wb_edge", 32'(commit_valid), 32'd0);
    idle();
    checkOutput("t5_commit", 32'(commit_valid), 32'd3);

    // 5b: same but stalled while the older completes
    t = nextTag;
    applyStimulus(2'b11, 2'b00, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(2'b00, 2'b10, 4'd0, t + 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(2'b00, 2'b01, t, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t5_stall_wb", 32'(commit_valid), 32'd0);
    applyStimulus(2'b00, 2'b00, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t5_stall_hold", 32'(commit_valid), 32'd0);
    checkOutput("t5_stall_count", 32'(rob_count), 32'd2);
    idle();
    checkOutput("t5_stall_release", 32'(commit_valid), 32'd3);
    checkOutput("t5_count", 32'(rob_count), 32'd0);

    // 6: five live entries squashed by flush; stale writeback has no effect
    t = nextTag;
    applyStimulus(2'b11, 2'b00, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(2'b11, 2'b00, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(2'b01, 2'b10, 4'd0, t + 4'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("t6_live_count", 32'(rob_count), 32'd5);
    applyStimulus(2'b00, 2'b00, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t6_flush_count", 32'(rob_count), 32'd0);
    checkOutput("t6_flush_empty", 32'(rob_empty), 32'd1);
    checkOutput("t6_flush_ready", 32'(alloc_ready), 32'd1);
    checkOutput("t6_flush_commit", 32'(commit_valid), 32'd0);
    applyStimulus(2'b00, 2'b01, t, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    checkOutput("t6_stale_wb_commit", 32'(commit_valid), 32'd0);
    checkOutput("t6_stale_wb_empty", 32'(rob_empty), 32'd1);
    // slot1-only dispatch after flush takes tag 0
    applyStimulus(2'b10, 2'b00, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(2'b00, 2'b01, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    checkOutput("t6_single_commit", 32'(commit_valid), 32'd1);
    checkOutput("t6_final_count", 32'(rob_count), 32'd0);

    idle();
    checkOutput("sb_drained", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
